// File: rtl/s1s2_unpack_pkg.sv
// Shared definitions for the S1S2 unpacker: FSM state encoding and a width helper.
package s1s2_unpack_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Address/index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/s1s2_unpack.sv
// Reads a run of S1S2 words, takes one half of each as a GF(2^m) element and packs d elements
// per row, MSB-first, into the row memory.
module s1s2_unpack
    import s1s2_unpack_pkg::*;
#(
    parameter int unsigned n        = 47,
    parameter int unsigned m        = 79,
    parameter int unsigned d        = 5,
    parameter int unsigned DELAY_rd = 1,
    localparam int unsigned WIDTH   = m * d,
    localparam int unsigned DEPTH   = n / d + (((n % d) != 0) ? 1 : 0),
    localparam int unsigned AW      = clog2_min1(2 * n),
    localparam int unsigned NW      = AW + 1,
    localparam int unsigned RW      = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [NW-1:0]    num,
    input  logic             half_sel,
    output logic             finish,
    input  logic [2*m-1:0]   S1S2_din,
    output logic [AW-1:0]    S1S2_addr,
    output logic             S1S2_rw,
    output logic [WIDTH-1:0] row_dout,
    output logic [RW-1:0]    row_addr,
    output logic             row_rw
);

    localparam int unsigned SW = clog2_min1(d);

    state_e              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [NW-1:0]       num_q, num_d;
    logic [NW-1:0]       iss_q, iss_d;
    logic [NW-1:0]       cap_q, cap_d;
    logic                half_q, half_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [DELAY_rd-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]    buf_q, buf_d;
    logic [WIDTH-1:0]    row_dout_q, row_dout_d;
    logic [RW-1:0]       row_idx_q, row_idx_d;
    logic                row_rw_q, row_rw_d;
    logic                last_wr_q, last_wr_d;
    logic                finish_q, finish_d;

    logic                issue;
    logic                capture;
    logic                last_elem;
    logic [m-1:0]        elem;
    logic [WIDTH-1:0]    row_new;

    always_comb begin
        issue     = (state_q == StRead);
        capture   = vld_q[DELAY_rd-1];
        elem      = half_q ? S1S2_din[m-1:0] : S1S2_din[2*m-1:m];
        last_elem = (cap_q == num_q - NW'(1));

        row_new = buf_q;
        for (int unsigned k = 0; k < d; k++) begin
            if (slot_q == SW'(k)) begin
                row_new[WIDTH-1-k*m -: m] = elem;
            end
        end

        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        half_d     = half_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        slot_d     = slot_q;
        buf_d      = buf_q;
        row_dout_d = '0;
        row_rw_d   = 1'b0;
        last_wr_d  = 1'b0;
        finish_d   = 1'b0;
        row_idx_d  = row_rw_q ? row_idx_q + RW'(1) : row_idx_q;

        // Each issued read is tagged so its data is taken exactly DELAY_rd cycles later.
        vld_d[0] = issue;
        for (int unsigned k = 1; k < DELAY_rd; k++) begin
            vld_d[k] = vld_q[k-1];
        end

        if (capture) begin
            cap_d = cap_q + NW'(1);
            if ((slot_q == SW'(d - 1)) || last_elem) begin
                row_rw_d   = 1'b1;
                row_dout_d = row_new;
                last_wr_d  = last_elem;
                buf_d      = '0;
                slot_d     = '0;
            end else begin
                buf_d  = row_new;
                slot_d = slot_q + SW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d    = base_addr;
                    num_d     = num;
                    half_d    = half_sel;
                    iss_d     = '0;
                    cap_d     = '0;
                    slot_d    = '0;
                    buf_d     = '0;
                    row_idx_d = '0;
                    state_d   = (num == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                iss_d = iss_q + NW'(1);
                if (iss_q == num_q - NW'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_wr_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                finish_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            base_q     <= '0;
            num_q      <= '0;
            half_q     <= 1'b0;
            iss_q      <= '0;
            cap_q      <= '0;
            slot_q     <= '0;
            vld_q      <= '0;
            buf_q      <= '0;
            row_dout_q <= '0;
            row_idx_q  <= '0;
            row_rw_q   <= 1'b0;
            last_wr_q  <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            half_q     <= half_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            slot_q     <= slot_d;
            vld_q      <= vld_d;
            buf_q      <= buf_d;
            row_dout_q <= row_dout_d;
            row_idx_q  <= row_idx_d;
            row_rw_q   <= row_rw_d;
            last_wr_q  <= last_wr_d;
            finish_q   <= finish_d;
        end
    end

    assign S1S2_addr = issue ? base_q + iss_q[AW-1:0] : '0;
    assign S1S2_rw   = 1'b0;
    assign row_dout  = row_dout_q;
    assign row_addr  = row_idx_q;
    assign row_rw    = row_rw_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_s1s2_unpack.sv
// Scoreboard bench for s1s2_unpack: a row-level reference model queues expected writes and a
// negedge monitor compares every row write and finish pulse against it.
module tb_s1s2_unpack;

    localparam int N     = 47;
    localparam int M     = 79;
    localparam int D     = 5;
    localparam int DLY   = 3;
    localparam int AW    = 7;
    localparam int NW    = AW + 1;
    localparam int RW    = 4;
    localparam int WIDTH = M * D;
    localparam int MEMSZ = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [NW-1:0]    num = '0;
    logic             half_sel = 1'b0;
    logic             finish;
    logic [2*M-1:0]   S1S2_din;
    logic [AW-1:0]    S1S2_addr;
    logic             S1S2_rw;
    logic [WIDTH-1:0] row_dout;
    logic [RW-1:0]    row_addr;
    logic             row_rw;

    always #5 clk = ~clk;

    s1s2_unpack #(
        .n        (N),
        .m        (M),
        .d        (D),
        .DELAY_rd (DLY)
    ) u_dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .base_addr (base_addr),
        .num       (num),
        .half_sel  (half_sel),
        .finish    (finish),
        .S1S2_din  (S1S2_din),
        .S1S2_addr (S1S2_addr),
        .S1S2_rw   (S1S2_rw),
        .row_dout  (row_dout),
        .row_addr  (row_addr),
        .row_rw    (row_rw)
    );

    // S1S2 memory with a DLY-cycle read pipeline.
    logic [2*M-1:0] mem [MEMSZ];
    logic [AW-1:0]  apipe [DLY];

    always @(posedge clk) begin
        apipe[0] <= S1S2_addr;
        for (int k = 1; k < DLY; k++) apipe[k] <= apipe[k-1];
    end
    assign S1S2_din = mem[apipe[DLY-1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0]    addr;
        logic [WIDTH-1:0] data;
        int               when;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  fin_exp  = -1;
    int  fin_seen = 0;
    int  wr_seen  = 0;
    int  n_vec    = 0;
    int  n_err    = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks every DUT output cycle while out of reset.
    always @(negedge clk) begin
        if (rst_b) begin
            chk("s1s2_rw", 512'(S1S2_rw), 512'(0));
            if (row_rw === 1'b1) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_row_write", 512'(row_rw), 512'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("row_addr", 512'(row_addr), 512'(mon_e.addr));
                    chk("row_dout", 512'(row_dout), 512'(mon_e.data));
                    chk("row_cycle", 512'(cyc), 512'(mon_e.when));
                end
            end else begin
                chk("row_dout_idle", 512'(row_dout), 512'(0));
            end
            if (finish === 1'b1) begin
                fin_seen++;
                if (fin_exp < 0) begin
                    chk("unexpected_finish", 512'(finish), 512'(0));
                end else begin
                    chk("finish_cycle", 512'(cyc), 512'(fin_exp));
                    fin_exp = -1;
                end
            end
        end
    end

    task automatic fill_mem(input bit idx_low);
        logic [159:0] t;
        for (int k = 0; k < MEMSZ; k++) begin
            t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            if (idx_low) t[M-1:0] = M'(k);
            mem[k] = t[2*M-1:0];
        end
    endtask

    // Reference: element j is one half of word base+j; rows take d elements each, zero padded.
    task automatic model(input int base, input int nm, input int half, input int c);
        logic [WIDTH-1:0] row;
        logic [2*M-1:0]   w;
        logic [M-1:0]     el;
        int               rows;
        int               last;
        int               j;
        rows = (nm + D - 1) / D;
        for (int r = 0; r < rows; r++) begin
            row = '0;
            for (int k = 0; k < D; k++) begin
                j = r * D + k;
                if (j < nm) begin
                    w  = mem[(base + j) % MEMSZ];
                    el = (half != 0) ? w[M-1:0] : w[2*M-1:M];
                end else begin
                    el = '0;
                end
                row = {row[WIDTH-M-1:0], el};
            end
            last = (((r + 1) * D < nm) ? (r + 1) * D : nm) - 1;
            exp_q.push_back('{addr: RW'(r), data: row, when: c + last + DLY + 2});
        end
        fin_exp = (nm == 0) ? c + 2 : c + nm + DLY + 3;
    endtask

    task automatic run_op(input int base, input int nm, input int half, input bit restart);
        int c;
        int f0;
        @(posedge clk); #1;
        base_addr = AW'(base);
        num       = NW'(nm);
        half_sel  = half[0];
        start     = 1'b1;
        c         = cyc;
        f0        = fin_seen;
        model(base, nm, half, c);
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom());
        num       = NW'($urandom_range(1, N));
        half_sel  = ~half_sel;
        for (int i = 0; i < nm; i++) begin
            start = restart && (i == 10);
            @(negedge clk);
            chk("s1s2_addr", 512'(S1S2_addr), 512'((base + i) % MEMSZ));
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (nm == 0) begin
            @(negedge clk);
            chk("s1s2_addr_idle", 512'(S1S2_addr), 512'(0));
        end
        for (int t = 0; t < 200 && fin_seen == f0; t++) @(posedge clk);
        chk("finish_count", 512'(fin_seen - f0), 512'(1));
        chk("rows_pending", 512'(exp_q.size()), 512'(0));
        repeat (3) @(posedge clk);
        chk("finish_once", 512'(fin_seen - f0), 512'(1));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_finish"}, 512'(finish), 512'(0));
        chk({tag, "_s1s2_addr"}, 512'(S1S2_addr), 512'(0));
        chk({tag, "_row_dout"}, 512'(row_dout), 512'(0));
        chk({tag, "_row_addr"}, 512'(row_addr), 512'(0));
        chk({tag, "_row_rw"}, 512'(row_rw), 512'(0));
    endtask

    task automatic reset_abort();
        int w0;
        int f0;
        @(posedge clk); #1;
        base_addr = '0;
        num       = NW'(N);
        half_sel  = 1'b0;
        start     = 1'b1;
        w0        = wr_seen;
        model(0, N, 0, cyc);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 300 && wr_seen < w0 + 3; t++) @(posedge clk);
        chk("writes_before_reset", 512'(wr_seen - w0), 512'(3));
        #1;
        rst_b = 1'b0;
        exp_q.delete();
        fin_exp = -1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        check_zero_outputs("after_reset");
        w0 = wr_seen;
        f0 = fin_seen;
        repeat (80) @(posedge clk);
        chk("writes_after_reset", 512'(wr_seen - w0), 512'(0));
        chk("finish_after_reset", 512'(fin_seen - f0), 512'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nm;
        int base;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_b = 1'b1;

        fill_mem(1'b0);
        run_op(0, N, 0, 1'b0);
        fill_mem(1'b1);
        run_op(N, N, 1, 1'b0);
        run_op(3, 0, 0, 1'b0);
        run_op(10, 5, 1, 1'b0);
        fill_mem(1'b0);
        run_op(0, N, 1, 1'b1);
        reset_abort();
        run_op(20, N, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            fill_mem($urandom_range(0, 1) != 0);
            nm   = $urandom_range(0, N);
            base = $urandom_range(0, 2 * N - nm);
            run_op(base, nm, $urandom_range(0, 1), (nm > 10) && ($urandom_range(0, 1) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
